// File: rtl/cache_controller_pkg.sv
// Shared definitions for the data cache between the MEM stage and the
// SRAM controller: geometry, FSM state encoding and address field helpers.
// No ports; imported by the interface, the way array, the top and the bench.
package cache_pkg;

    localparam int SETS    = 64;
    localparam int INDEX_W = 6;
    localparam int TAG_W   = 11;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SRAM_READ  = 2'd1,
        SRAM_WRITE = 2'd2
    } state_t;

    // Word address bits [INDEX_W+1:2] select the set.
    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return addr[INDEX_W+1:2];
    endfunction

    // SRAM space ends at bit 18, so the tag is the remaining bits above the index.
    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[INDEX_W+TAG_W+1:INDEX_W+2];
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Bus bundle for cache_controller: the MEM stage request side and the SRAM
// controller side.
//   slave  : the cache controller itself
//   master : the environment (MEM stage + SRAM controller)
// Handshake semantics:
//   MEM side   - mem_rd_en / mem_wr_en are held, with address and writeData
//                stable, until mem_ready is seen high; that cycle completes
//                the request (readData valid when mem_ready & mem_rd_en).
//   SRAM side  - sram_rd_en / sram_wr_en are held until sram_ready is seen
//                high; that cycle completes the SRAM access and the enable
//                drops on the following cycle.
interface cache_controller_if;
    import cache_pkg::*;

    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              mem_ready;
    logic              sram_wr_en;
    logic              sram_rd_en;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_writeData;
    logic [DATA_W-1:0] sram_readData;
    logic              sram_ready;

    modport slave (
        input  mem_rd_en, mem_wr_en, address, writeData, sram_readData, sram_ready,
        output readData, mem_ready, sram_wr_en, sram_rd_en, sram_address, sram_writeData
    );

    modport master (
        output mem_rd_en, mem_wr_en, address, writeData, sram_readData, sram_ready,
        input  readData, mem_ready, sram_wr_en, sram_rd_en, sram_address, sram_writeData
    );

endinterface

// File: rtl/cache_controller_way_array.sv
// Storage for the 2-way cache: per-way tag, valid and data arrays plus one
// LRU bit per set. Asynchronous read of the addressed set, synchronous write.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears valid/LRU only)
//   idx              set index for both read and write
//   tag0/1, data0/1, valid0/1, lru   contents of the addressed set
//   we, we_way       write data of way we_way at idx
//   we_fill          with we: also write tag and set valid (line fill)
//   wtag, wdata      tag / data to write
//   lru_we, lru_d    update the LRU bit of set idx
module cache_way_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx,
    output logic [TAG_W-1:0]   tag0,
    output logic [TAG_W-1:0]   tag1,
    output logic [DATA_W-1:0]  data0,
    output logic [DATA_W-1:0]  data1,
    output logic               valid0,
    output logic               valid1,
    output logic               lru,
    input  logic               we,
    input  logic               we_way,
    input  logic               we_fill,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               lru_we,
    input  logic               lru_d
);

    logic [TAG_W-1:0]  tag_q  [2][SETS];
    logic [DATA_W-1:0] data_q [2][SETS];
    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   lru_q;

    assign tag0   = tag_q[0][idx];
    assign tag1   = tag_q[1][idx];
    assign data0  = data_q[0][idx];
    assign data1  = data_q[1][idx];
    assign valid0 = valid_q[0][idx];
    assign valid1 = valid_q[1][idx];
    assign lru    = lru_q[idx];

    // Tag and data are never reset; the valid bits make their content irrelevant.
    always_ff @(posedge clk) begin
        if (we) begin
            data_q[we_way][idx] <= wdata;
            if (we_fill) begin
                tag_q[we_way][idx] <= wtag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            if (we && we_fill) begin
                valid_q[we_way][idx] <= 1'b1;
            end
            if (lru_we) begin
                lru_q[idx] <= lru_d;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache.
// Read hits complete in the request cycle; read misses fetch one word from
// the SRAM controller and fill a victim way; every write goes to SRAM and a
// write hit also refreshes the cached word.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         cache_controller_if.slave (MEM stage + SRAM controller signals)
//   state_dbg   current FSM state
module cache_controller
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus,
    output state_t             state_dbg
);

    state_t             state;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [TAG_W-1:0]   tag0, tag1;
    logic [DATA_W-1:0]  data0, data1;
    logic               valid0, valid1, lru;
    logic               hit0, hit1, hit, hit_way, victim;
    logic               we, we_way, we_fill, lru_we, lru_d;
    logic [DATA_W-1:0]  wdata;

    assign idx = get_index(bus.address);
    assign tag = get_tag(bus.address);

    cache_way_array u_ways (
        .clk     (clk),
        .rst     (rst),
        .idx     (idx),
        .tag0    (tag0),
        .tag1    (tag1),
        .data0   (data0),
        .data1   (data1),
        .valid0  (valid0),
        .valid1  (valid1),
        .lru     (lru),
        .we      (we),
        .we_way  (we_way),
        .we_fill (we_fill),
        .wtag    (tag),
        .wdata   (wdata),
        .lru_we  (lru_we),
        .lru_d   (lru_d)
    );

    // The two ways can never hold the same tag in one set, so at most one hits.
    assign hit0    = valid0 && (tag0 == tag);
    assign hit1    = valid1 && (tag1 == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;

    // Fill an empty way first; only when both are valid does LRU decide.
    assign victim = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);

    // SRAM enables come from the registered state only, so they drop the
    // cycle after sram_ready and the SRAM controller cannot re-trigger.
    assign bus.sram_rd_en     = (state == SRAM_READ);
    assign bus.sram_wr_en     = (state == SRAM_WRITE);
    assign bus.sram_address   = bus.address;
    assign bus.sram_writeData = bus.writeData;
    assign state_dbg          = state;

    // During a miss completion the SRAM word bypasses the array.
    assign bus.readData = (state == SRAM_READ) ? bus.sram_readData
                                               : (hit_way ? data1 : data0);

    always_comb begin
        bus.mem_ready = 1'b1;
        we            = 1'b0;
        we_way        = 1'b0;
        we_fill       = 1'b0;
        wdata         = bus.writeData;
        lru_we        = 1'b0;
        lru_d         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_wr_en) begin
                    bus.mem_ready = 1'b0;
                end else if (bus.mem_rd_en) begin
                    bus.mem_ready = hit;
                    if (hit) begin
                        lru_we = 1'b1;
                        lru_d  = ~hit_way;
                    end
                end
            end
            SRAM_READ: begin
                bus.mem_ready = bus.sram_ready;
                if (bus.sram_ready) begin
                    we      = 1'b1;
                    we_way  = victim;
                    we_fill = 1'b1;
                    wdata   = bus.sram_readData;
                    lru_we  = 1'b1;
                    lru_d   = ~victim;
                end
            end
            SRAM_WRITE: begin
                bus.mem_ready = bus.sram_ready;
                // Hit is re-evaluated on the held address; misses do not allocate.
                if (bus.sram_ready && hit) begin
                    we     = 1'b1;
                    we_way = hit_way;
                    lru_we = 1'b1;
                    lru_d  = ~hit_way;
                end
            end
            default: begin
                bus.mem_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // Write wins when both enables are high.
                    if (bus.mem_wr_en) begin
                        state <= SRAM_WRITE;
                    end else if (bus.mem_rd_en && !hit) begin
                        state <= SRAM_READ;
                    end
                end
                SRAM_READ: begin
                    if (bus.sram_ready) begin
                        state <= IDLE;
                    end
                end
                SRAM_WRITE: begin
                    if (bus.sram_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;
  import cache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_controller_if bus();
  state_t state_dbg;

  cache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- SRAM controller + SRAM model ----------------
  // Read takes 6 cycles including the request cycle, write takes 3.
  // Unwritten words read as 0xA500_0000 ^ address.
  logic [31:0]   sram_mem [0:1023];
  logic [1023:0] written;
  logic          mem_clear;
  int            cnt;
  logic [9:0]    sidx;

  assign sidx = bus.sram_address[11:2];
  assign bus.sram_ready = (bus.sram_rd_en && cnt == 5) || (bus.sram_wr_en && cnt == 2);
  assign bus.sram_readData = written[sidx] ? sram_mem[sidx] : (32'hA500_0000 ^ bus.sram_address);

  always @(posedge clk) begin
    if (mem_clear) begin
      written <= '0;
    end else if (bus.sram_wr_en && bus.sram_ready) begin
      sram_mem[sidx] <= bus.sram_writeData;
      written[sidx]  <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
    end else if (bus.sram_rd_en || bus.sram_wr_en) begin
      cnt <= bus.sram_ready ? 0 : cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    logic [9:0] i;
    i = a[11:2];
    return written[i] ? sram_mem[i] : (32'hA500_0000 ^ a);
  endfunction

  // ---------------- scoreboard ----------------
  // Entry: [42] compare readData, [41] sram_rd_en seen, [40] sram_wr_en seen,
  //        [39:32] stall cycles, [31:0] read data
  localparam int W = 43;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  int   tests = 0;
  int   fails = 0;
  logic mon_en;
  int   stall;
  logic rd_seen, wr_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts stall cycles and SRAM enables of the current request,
  // and checks against the queued expectation when mem_ready completes it.
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      stall = 0; rd_seen = 1'b0; wr_seen = 1'b0;
    end else if (bus.mem_rd_en || bus.mem_wr_en) begin
      if (bus.sram_rd_en) rd_seen = 1'b1;
      if (bus.sram_wr_en) wr_seen = 1'b1;
      if (!bus.mem_ready) begin
        stall++;
      end else begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_completion: got completion expected none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("stall_cycles", stall, {24'b0, e[39:32]});
          chk("sram_rd_en_seen", {31'b0, rd_seen}, {31'b0, e[41]});
          chk("sram_wr_en_seen", {31'b0, wr_seen}, {31'b0, e[40]});
          if (e[42]) chk("readData", bus.readData, e[31:0]);
        end
        stall = 0; rd_seen = 1'b0; wr_seen = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic cmp_d, input logic exp_rd,
                        input logic exp_wr, input int exp_stall);
    int n;
    @(posedge clk); #1;
    bus.mem_rd_en = rd; bus.mem_wr_en = wr; bus.address = a; bus.writeData = wd;
    exp_q.push_back({cmp_d, exp_rd, exp_wr, exp_stall[7:0], exp_d});
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bus.mem_ready && n < 40);
    if (!bus.mem_ready) begin
      tests++; fails++;
      $display("FAIL timeout: got no mem_ready expected completion addr 0x%08h", a);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
  endtask

  task automatic rd_miss(input logic [31:0] a, input logic [31:0] d);
    do_req(1'b1, 1'b0, a, 32'h0, d, 1'b1, 1'b1, 1'b0, 6);
  endtask
  task automatic rd_hit(input logic [31:0] a, input logic [31:0] d);
    do_req(1'b1, 1'b0, a, 32'h0, d, 1'b1, 1'b0, 1'b0, 0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    do_req(1'b0, 1'b1, a, d, 32'h0, 1'b0, 1'b0, 1'b1, 3);
  endtask
  task automatic both(input logic [31:0] a, input logic [31:0] d);
    do_req(1'b1, 1'b1, a, d, 32'h0, 1'b0, 1'b0, 1'b1, 3);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    mon_en = 1'b0; rst = 1'b1; bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; mon_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mon_en = 1'b0; rst = 1'b1; mem_clear = 1'b1;
    bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
    bus.address = 32'h0; bus.writeData = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_clear = 1'b0; mon_en = 1'b1;

    @(negedge clk);
    chk("reset_mem_ready", {31'b0, bus.mem_ready}, 32'd1);
    chk("reset_sram_rd_en", {31'b0, bus.sram_rd_en}, 32'd0);
    chk("reset_sram_wr_en", {31'b0, bus.sram_wr_en}, 32'd0);
    chk("reset_state", {30'b0, state_dbg}, {30'b0, IDLE});

    // Miss then hit on the same word
    rd_miss(32'h0000_0100, 32'hA500_0100);
    rd_hit (32'h0000_0100, 32'hA500_0100);

    // Write hit: SRAM updated and cached copy refreshed
    wr(32'h0000_0100, 32'hDEAD_BEEF);
    go_idle();
    chk("sram_word_0x100", sram_word(32'h0000_0100), 32'hDEAD_BEEF);
    rd_hit(32'h0000_0100, 32'hDEAD_BEEF);

    // Write miss: no allocation, later read misses
    wr(32'h0000_0200, 32'h1234_5678);
    go_idle();
    chk("sram_word_0x200", sram_word(32'h0000_0200), 32'h1234_5678);
    rd_miss(32'h0000_0200, 32'h1234_5678);

    // Both enables high: write path only
    both(32'h0000_0300, 32'hCAFE_F00D);
    go_idle();
    chk("sram_word_0x300", sram_word(32'h0000_0300), 32'hCAFE_F00D);
    rd_miss(32'h0000_0300, 32'hCAFE_F00D);
    rd_hit (32'h0000_0200, 32'h1234_5678);

    // Reset in the middle of a read miss
    @(posedge clk); #1;
    mon_en = 1'b0;
    bus.mem_rd_en = 1'b1; bus.mem_wr_en = 1'b0; bus.address = 32'h0000_0400;
    @(posedge clk);
    @(negedge clk);
    chk("abort_pre_state", {30'b0, state_dbg}, {30'b0, SRAM_READ});
    chk("abort_pre_sram_rd_en", {31'b0, bus.sram_rd_en}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; bus.mem_rd_en = 1'b0;
    @(negedge clk);
    chk("abort_state", {30'b0, state_dbg}, {30'b0, IDLE});
    chk("abort_sram_rd_en", {31'b0, bus.sram_rd_en}, 32'd0);
    chk("abort_sram_wr_en", {31'b0, bus.sram_wr_en}, 32'd0);
    chk("abort_mem_ready", {31'b0, bus.mem_ready}, 32'd1);
    mon_en = 1'b1;
    rd_miss(32'h0000_0200, 32'h1234_5678);
    rd_miss(32'h0000_0300, 32'hCAFE_F00D);

    // Set 0 fill and replacement order from a clean cache
    do_reset();
    rd_miss(32'h0000_0000, 32'hA500_0000);
    rd_miss(32'h0000_0100, 32'hDEAD_BEEF);
    rd_hit (32'h0000_0000, 32'hA500_0000);
    rd_miss(32'h0000_0200, 32'h1234_5678);
    rd_hit (32'h0000_0000, 32'hA500_0000);
    rd_miss(32'h0000_0100, 32'hDEAD_BEEF);
    rd_hit (32'h0000_0000, 32'hA500_0000);

    // A different set is independent
    rd_miss(32'h0000_0104, 32'hA500_0104);
    rd_hit (32'h0000_0104, 32'hA500_0104);
    rd_hit (32'h0000_0100, 32'hDEAD_BEEF);

    go_idle();
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected end of test by t=100000");
    $fatal(1, "watchdog");
  end

endmodule
